// File: rtl/cb_reader_pkg.sv
// Shared types and default constants for the circular_buffer read-side UART drain.
package cb_reader_pkg;

    localparam int unsigned CB_CLKS_PER_BIT  = 104;
    localparam int unsigned CB_SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_SETTLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for circular_buffer flags crossing into the clk domain.
module sync_ff2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cb_uart_reader.sv
// Pops bytes from circular_buffer via r_clk and streams each out as a UART 8N1 frame.
module cb_uart_reader
    import cb_reader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = CB_CLKS_PER_BIT,
    parameter int unsigned SETTLE_CYCLES = CB_SETTLE_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        has_data,
    input  logic [7:0]  r_data,
    output logic        r_clk,
    output logic        tx,
    output logic        busy,
    output logic [15:0] sent_count
);

    localparam int unsigned    TW            = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  BIT_RELOAD    = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    logic hd_s;

    state_e        state_q,      state_d;
    logic [TW-1:0] timer_q,      timer_d;
    logic [3:0]    settle_q,     settle_d;
    logic [2:0]    bit_idx_q,    bit_idx_d;
    logic [7:0]    shift_q,      shift_d;
    logic          tx_q,         tx_d;
    logic          r_clk_q,      r_clk_d;
    logic [15:0]   sent_count_q, sent_count_d;

    sync_ff2 u_hd_sync (
        .clk (clk),
        .rst (rst),
        .d   (has_data),
        .q   (hd_s)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        settle_d     = settle_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        r_clk_d      = 1'b0;
        sent_count_d = sent_count_q;

        case (state_q)
            ST_IDLE: begin
                if (en && hd_s) begin
                    state_d = ST_STROBE;
                    r_clk_d = 1'b1;
                end
            end
            ST_STROBE: begin
                settle_d = SETTLE_RELOAD;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    shift_d = r_data;
                    tx_d    = 1'b0;
                    timer_d = BIT_RELOAD;
                    state_d = ST_START;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_START: begin
                if (timer_q == '0) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    timer_d   = BIT_RELOAD;
                    state_d   = ST_DATA;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // tx is registered, so it takes the bit that lands in shift[0] after this shift
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == '0) begin
                    sent_count_d = sent_count_q + 16'd1;
                    if (en && hd_s) begin
                        state_d = ST_STROBE;
                        r_clk_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            settle_q     <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            r_clk_q      <= 1'b0;
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            settle_q     <= settle_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            r_clk_q      <= r_clk_d;
            sent_count_q <= sent_count_d;
        end
    end

    assign r_clk      = r_clk_q;
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE);
    assign sent_count = sent_count_q;

endmodule

// File: tb/tb_cb_uart_reader.sv
// Directed bench for cb_uart_reader against a small behavioural circular_buffer read port.
module tb_cb_uart_reader;

    localparam int unsigned CPB = 4;
    localparam int unsigned SET = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        has_data;
    logic [7:0]  r_data = 8'h00;
    logic        r_clk;
    logic        tx;
    logic        busy;
    logic [15:0] sent_count;

    logic [7:0]  mem [0:255];
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    int unsigned empty_pops = 0;

    int unsigned cyc = 0;
    int unsigned rclk_pulses = 0;
    int unsigned last_rclk_cyc = 0;
    int unsigned last_start = 0;

    int checks = 0;
    int errors = 0;

    cb_uart_reader #(
        .CLKS_PER_BIT  (CPB),
        .SETTLE_CYCLES (SET)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .has_data   (has_data),
        .r_data     (r_data),
        .r_clk      (r_clk),
        .tx         (tx),
        .busy       (busy),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    assign has_data = (wr_cnt != rd_cnt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (r_clk) begin
            rclk_pulses   <= rclk_pulses + 1;
            last_rclk_cyc <= cyc;
        end
    end

    // buffer read port: pop on the rising edge of the strobe
    always @(posedge r_clk) begin
        if (rd_cnt == wr_cnt) begin
            empty_pops <= empty_pops + 1;
        end else begin
            r_data <= mem[rd_cnt[7:0]];
            rd_cnt <= rd_cnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_cnt[7:0]] = b;
        wr_cnt = wr_cnt + 1;
    endtask

    // Samples tx once per cycle over the whole 10-bit frame, so bit width is checked too.
    task automatic recv_frame(input string tag, input logic [7:0] b);
        int          n = 0;
        int          k;
        logic [39:0] smp;
        logic [39:0] expv;
        int unsigned sc;
        smp  = '0;
        expv = '0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 2000);
        if (tx !== 1'b0) begin
            check_eq({tag, "_timeout"}, 64'(tx), 64'(0));
            return;
        end
        sc     = cyc;
        smp[0] = tx;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            smp[i] = tx;
        end
        for (int i = 0; i < 40; i++) begin
            k = i / 4;
            if (k == 0)      expv[i] = 1'b0;
            else if (k == 9) expv[i] = 1'b1;
            else             expv[i] = b[k-1];
        end
        check_eq({tag, "_bits"}, 64'(smp), 64'(expv));
        check_eq({tag, "_lat"}, 64'(sc - last_rclk_cyc), 64'(1 + SET));
        last_start = sc;
    endtask

    initial begin
        logic        saw_rclk;
        logic        saw_tx0;
        int unsigned s1, s2, s3;
        int unsigned p0;
        int          n;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", 64'(tx), 64'(1));
        check_eq("rst_rclk", 64'(r_clk), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_count", 64'(sent_count), 64'(0));
        rst = 1'b0;
        en  = 1'b1;

        saw_rclk = 1'b0;
        saw_tx0  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (r_clk)     saw_rclk = 1'b1;
            if (tx !== 1'b1) saw_tx0 = 1'b1;
        end
        check_eq("empty_rclk", 64'(saw_rclk), 64'(0));
        check_eq("empty_tx", 64'(saw_tx0), 64'(0));

        // single byte, with exact pop latency
        p0 = rclk_pulses;
        push(8'h55);
        @(negedge clk);
        @(negedge clk);
        check_eq("pop_lat_early", 64'(r_clk), 64'(0));
        @(negedge clk);
        check_eq("pop_lat", 64'(r_clk), 64'(1));
        recv_frame("single", 8'h55);
        @(negedge clk);
        check_eq("single_count", 64'(sent_count), 64'(1));
        check_eq("single_pulses", 64'(rclk_pulses - p0), 64'(1));
        check_eq("single_hd", 64'(has_data), 64'(0));
        check_eq("single_busy", 64'(busy), 64'(0));

        // burst, back-to-back frames
        push(8'h55);
        push(8'h5A);
        push(8'h00);
        recv_frame("burst0", 8'h55);
        s1 = last_start;
        recv_frame("burst1", 8'h5A);
        s2 = last_start;
        recv_frame("burst2", 8'h00);
        s3 = last_start;
        check_eq("burst_gap01", 64'(s2 - s1), 64'(40 + 1 + SET));
        check_eq("burst_gap12", 64'(s3 - s2), 64'(40 + 1 + SET));
        @(negedge clk);
        check_eq("burst_count", 64'(sent_count), 64'(4));
        check_eq("burst_busy", 64'(busy), 64'(0));

        // gating with en
        en = 1'b0;
        p0 = rclk_pulses;
        push(8'hA5);
        saw_rclk = 1'b0;
        saw_tx0  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (r_clk)       saw_rclk = 1'b1;
            if (tx !== 1'b1) saw_tx0 = 1'b1;
        end
        check_eq("gate_rclk", 64'(saw_rclk), 64'(0));
        check_eq("gate_tx", 64'(saw_tx0), 64'(0));
        en = 1'b1;
        @(negedge clk);
        check_eq("gate_rise", 64'(r_clk), 64'(1));
        fork
            recv_frame("gate", 8'hA5);
            begin
                repeat (20) @(negedge clk);
                en = 1'b0;
                push(8'h77);
            end
        join
        @(negedge clk);
        check_eq("gate_count", 64'(sent_count), 64'(5));
        repeat (10) @(negedge clk);
        check_eq("gate_hold", 64'(rclk_pulses - p0), 64'(1));
        check_eq("gate_idle", 64'(busy), 64'(0));
        en = 1'b1;
        recv_frame("gate2", 8'h77);
        @(negedge clk);
        check_eq("gate2_count", 64'(sent_count), 64'(6));

        // reset during DATA bit 3
        push(8'h3C);
        push(8'hC3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 2000);
        check_eq("rst_start", 64'(tx), 64'(0));
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_tx", 64'(tx), 64'(1));
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_count", 64'(sent_count), 64'(0));
        check_eq("midrst_rclk", 64'(r_clk), 64'(0));
        rst = 1'b0;
        recv_frame("after_rst", 8'hC3);
        @(negedge clk);
        check_eq("after_rst_count", 64'(sent_count), 64'(1));

        // counter wrap
        force dut.sent_count_q = 16'hFFFE;
        @(negedge clk);
        @(negedge clk);
        release dut.sent_count_q;
        @(negedge clk);
        check_eq("wrap_preload", 64'(sent_count), 64'(16'hFFFE));
        push(8'h11);
        push(8'h22);
        recv_frame("wrap0", 8'h11);
        @(negedge clk);
        check_eq("wrap_ffff", 64'(sent_count), 64'(16'hFFFF));
        recv_frame("wrap1", 8'h22);
        @(negedge clk);
        check_eq("wrap_zero", 64'(sent_count), 64'(16'h0000));

        repeat (5) @(negedge clk);
        check_eq("empty_pops", 64'(empty_pops), 64'(0));
        check_eq("all_popped", 64'(rd_cnt), 64'(wr_cnt));
        check_eq("pulse_total", 64'(rclk_pulses), 64'(wr_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_uart_reader.md
# cb_uart_reader

Read-side consumer for the `circular_buffer`: watches the buffer's `has_data` flag and pulses the buffer's `r_clk` to pop one byte. It then transmits that byte as a UART 8N1 frame on `tx`. It sits between the PDM sample buffer and the FPGA's serial pin, and drains captured audio bytes to the host in the order they were written.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: `clk` cycles per UART bit (12 MHz / 115200). Legal range 4..65535.
- `SETTLE_CYCLES`, default 2: `clk` cycles waited after the `r_clk` falling edge before sampling `r_data`. Legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: allows new pops; an in-flight frame always completes.
- `has_data` in 1: buffer non-empty flag, asynchronous to `clk`.
- `r_data` in 8: buffer read data, valid `SETTLE_CYCLES` after the `r_clk` pulse.
- `r_clk` out 1: buffer read strobe; registered, one `clk` cycle high per pop.
- `tx` out 1: UART line, idle high, LSB first.
- `busy` out 1: high in every state except IDLE.
- `sent_count` out 16: count of completed frames; wraps 0xFFFF -> 0x0000.

## Operation
- `has_data` passes through a 2-flop synchronizer to give `hd_s`. Decisions use only `hd_s`.
- States and transitions:
  - IDLE: if `en & hd_s`, go to STROBE.
  - STROBE, 1 cycle: `r_clk`=1. Go to SETTLE.
  - SETTLE, `SETTLE_CYCLES` cycles: `r_clk`=0. On the last cycle, latch `r_data` into an 8-bit shift register. Go to START.
  - START, `CLKS_PER_BIT` cycles: `tx`=0.
  - DATA, 8 × `CLKS_PER_BIT` cycles: `tx`=shift[0]; shift right at each bit boundary.
  - STOP, `CLKS_PER_BIT` cycles: `tx`=1.
  - On the last STOP cycle: increment `sent_count`. Then go to STROBE if `en & hd_s`, else IDLE. Back-to-back frames have no idle bit.
- Bit timer: `$clog2(CLKS_PER_BIT)`-bit down-counter, reloaded at each state or bit entry. Bit index: 3 bits.
- `en` falling during STROBE..STOP has no effect until the STOP exit.
- Stale flag: the popped byte's `has_data` drop reaches `hd_s` within 3 cycles. The frame lasts at least 40 cycles, so no double pop can occur.
- Empty pop is impossible by construction. `r_clk` only rises when `hd_s`=1.
- Reset mid-frame: the next cycle gives `tx`=1, `r_clk`=0, IDLE. The popped byte is lost, which is accepted. Synchronizer flops clear to 0.

## Timing
- Reset values: `tx`=1, `r_clk`=0, `busy`=0, `sent_count`=0, state IDLE.
- Pop latency: `has_data` rises before edge n and `en`=1. `hd_s`=1 after edge n+1. `r_clk`=1 after edge n+2 and for that cycle only.
- `r_data` is sampled on the edge ending the SETTLE_CYCLES-th cycle after `r_clk` falls.
- `tx` falls on the edge following the sample. It falls exactly `1+SETTLE_CYCLES` cycles after `r_clk` rises.
- Frame length: 10 × `CLKS_PER_BIT` cycles from `tx` falling to STOP end.
- `sent_count` updates on the same edge that leaves STOP.
- Back-to-back: the next `r_clk` rises on the edge leaving STOP.
- `busy` rises with `r_clk` and falls on the edge entering IDLE.

## Structure
- Shared package `cb_reader_pkg`:
  - State enum (IDLE, STROBE, SETTLE, START, DATA, STOP).
  - Default parameter constants `CB_CLKS_PER_BIT`=104 and `CB_SETTLE_CYCLES`=2.
- Sub-module `sync_ff2`: a generic 2-flop synchronizer with synchronous active-high reset. It is reused wherever `circular_buffer` flags cross into `clk`.
- The UART shifter stays inline. It is too small to split out.

## Test plan
Use `CLKS_PER_BIT`=4 and `SETTLE_CYCLES`=2 unless stated otherwise. The bench instantiates the real `circular_buffer` with `r_clk` driven by this block.

- Single byte: write 0x55 then wait. Required:
  - `r_clk` pulses once.
  - `tx` gives start 0, then bits 1,0,1,0,1,0,1,0 (LSB first), then stop 1, each bit 4 cycles.
  - `sent_count`=1.
  - `has_data`=0 afterwards.
- Burst: write 0x55, 0x5A, 0x00. Required:
  - Three contiguous frames in that order with no idle between.
  - `r_clk` rises on the edge leaving each STOP.
  - `sent_count`=3, then IDLE with `busy`=0.
- Gating: hold `en`=0 and write 0xA5. Required:
  - No `r_clk` and `tx`=1.
  - Raising `en` gives `r_clk` within 1 cycle (`hd_s` already high) and frame 0xA5.
  - Dropping `en` mid-frame still completes that frame.
- Reset mid-frame: assert `rst` for 1 cycle during DATA bit 3. Required:
  - Next cycle gives `tx`=1, `busy`=0, `sent_count`=0.
  - Remaining buffered bytes are sent afterwards, uncorrupted.
- Empty buffer: after reset with no writes, run 1000 cycles. Required: `r_clk` never rises and `tx` stays constant 1.
- Counter wrap: preload 0xFFFE frames by force (or a long run), then send 2 bytes. Required: `sent_count` goes 0xFFFF -> 0x0000.
